dmem_arbiter: RTL and testbench

- Data-memory access controller sitting between two memory masters and the single-port word-organised data RAM (10-bit word address, 4-bit byte-lane select, synchronous write, combinational read gated by load enable).
- Master 0 is the CPU load/store unit; master 1 is the debug/DMA loader.
- Round-robin arbitration; converts byte address plus size into RAM word address, lane select and replicated write data; aligns and sign/zero-extends load data; flags illegal accesses.

---
 rtl/dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Data-memory access controller between two memory masters and a single-port
//   word-organised data RAM. Master 0 is the CPU load/store unit, master 1 the
//   debug/DMA loader. Requests are arbitrated round-robin. The winner's fields
//   are latched, converted into a RAM word access (word address, byte-lane
//   select, replicated write data) and load data is aligned and sign/zero
//   extended. Illegal or misaligned accesses never touch the RAM and complete
//   with err=1.
//
//   Each transaction takes three cycles: IDLE (arbitrate) -> ACCESS (gnt, RAM
//   strobe) -> RESP (rvalid with rdata/err).
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   mN_req          request, held until mN_gnt
//   mN_we           1 = store, 0 = load
//   mN_size         00 byte, 01 halfword, 10 word, 11 illegal
//   mN_sext         loads: 1 sign-extend, 0 zero-extend
//   mN_addr         byte address
//   mN_wdata        right-aligned store data
//   mN_gnt          one-cycle grant (request fields have been latched)
//   mN_rvalid       one-cycle completion strobe
//   mN_rdata        aligned/extended load data, valid with mN_rvalid
//   mN_err          misaligned/illegal access flag, valid with mN_rvalid
//   ram_we/ram_ld   RAM write / load enable
//   ram_sel         RAM byte-lane select
//   ram_addr        RAM word address (addr[ADDR_W-1:2])
//   ram_din         RAM write data
//   ram_dout        RAM read data (combinational)
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic              m0_sext,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic              m1_sext,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,

    output logic              ram_we,
    output logic [3:0]        ram_sel,
    output logic              ram_ld,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                last_q,  last_d;   // master granted most recently
    logic                win_q,   win_d;    // master owning the current access
    logic                we_q,    we_d;
    logic [1:0]          size_q,  size_d;
    logic                sext_q,  sext_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q,   err_d;

    logic                pick;
    logic                legal;
    logic [3:0]          sel_w;
    logic [31:0]         din_w;
    logic [31:0]         shifted;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;
    logic [31:0]         load_w;

    // ------------------------------------------------------------------
    // Legality and lane decode of the latched access
    // ------------------------------------------------------------------
    always_comb begin
        legal = 1'b0;
        sel_w = '0;
        din_w = wdata_q;
        case (size_q)
            2'b00: begin
                legal = 1'b1;
                sel_w = 4'b0001 << addr_q[1:0];
                din_w = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                legal = ~addr_q[0];
                sel_w = addr_q[1] ? 4'b1100 : 4'b0011;
                din_w = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                legal = (addr_q[1:0] == 2'b00);
                sel_w = 4'b1111;
                din_w = wdata_q;
            end
            default: begin
                legal = 1'b0;
                sel_w = '0;
                din_w = wdata_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data alignment and extension
    // ------------------------------------------------------------------
    always_comb begin
        shifted = ram_dout >> {addr_q[1:0], 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
        case (size_q)
            2'b00:   load_w = {{24{sext_q & byte_v[7]}}, byte_v};
            2'b01:   load_w = {{16{sext_q & half_v[15]}}, half_v};
            default: load_w = ram_dout;
        endcase
    end

    // Only one requester: it wins regardless of the pointer. Both: the one
    // not granted last time wins.
    assign pick = (m0_req && m1_req) ? ~last_q : ~m0_req;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        we_d    = we_q;
        size_d  = size_q;
        sext_d  = sext_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    win_d   = pick;
                    last_d  = pick;
                    we_d    = pick ? m1_we    : m0_we;
                    size_d  = pick ? m1_size  : m0_size;
                    sext_d  = pick ? m1_sext  : m0_sext;
                    addr_d  = pick ? m1_addr  : m0_addr;
                    wdata_d = pick ? m1_wdata : m0_wdata;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Stores and illegal accesses respond with zero data.
                rdata_d = (legal && !we_q) ? load_w : '0;
                err_d   = ~legal;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (all decoded from registered state, so reset clears them
    // asynchronously)
    // ------------------------------------------------------------------
    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        m0_err    = 1'b0;
        m1_err    = 1'b0;
        ram_we    = 1'b0;
        ram_ld    = 1'b0;
        ram_sel   = '0;
        ram_addr  = '0;
        ram_din   = '0;

        if (state_q == S_ACCESS) begin
            m0_gnt = ~win_q;
            m1_gnt = win_q;
            if (legal) begin
                ram_we   = we_q;
                ram_ld   = ~we_q;
                ram_sel  = sel_w;
                ram_addr = addr_q[ADDR_W-1:2];
                ram_din  = we_q ? din_w : '0;
            end
        end

        if (state_q == S_RESP) begin
            if (win_q) begin
                m1_rvalid = 1'b1;
                m1_rdata  = rdata_q;
                m1_err    = err_q;
            end else begin
                m0_rvalid = 1'b1;
                m0_rdata  = rdata_q;
                m0_err    = err_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sext_q  <= sext_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m0_we, m0_sext;
    logic [1:0]        m0_size;
    logic [ADDR_W-1:0] m0_addr;
    logic [31:0]       m0_wdata;
    logic              m0_gnt, m0_rvalid, m0_err;
    logic [31:0]       m0_rdata;
    logic              m1_req, m1_we, m1_sext;
    logic [1:0]        m1_size;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_wdata;
    logic              m1_gnt, m1_rvalid, m1_err;
    logic [31:0]       m1_rdata;
    logic              ram_we, ram_ld;
    logic [3:0]        ram_sel;
    logic [ADDR_W-3:0] ram_addr;
    logic [31:0]       ram_din, ram_dout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_sext(m0_sext),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_sext(m1_sext),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_we(ram_we), .ram_sel(ram_sel), .ram_ld(ram_ld),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Data RAM: synchronous byte-lane write, combinational read gated by load.
    logic [31:0] ram_mem [1024] = '{default: '0};
    assign ram_dout = ram_ld ? ram_mem[ram_addr] : 32'h0;
    always @(posedge clk) begin
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (ram_sel[i]) ram_mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
    end

    // Reference model: flat byte-addressed little-endian memory.
    logic [7:0] ref_mem [4096] = '{default: '0};

    function automatic logic ref_legal(input logic [1:0] s, input logic [11:0] a);
        if (s == 2'd0) return 1'b1;
        if (s == 2'd1) return (a % 2) == 0;
        if (s == 2'd2) return (a % 4) == 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [1:0] s, input logic [11:0] a);
        int lane = int'(a % 4);
        if (s == 2'd0) return 4'(1 << lane);
        if (s == 2'd1) return (lane == 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_din(input logic [1:0] s, input logic [31:0] w);
        if (s == 2'd0) return {4{w[7:0]}};
        if (s == 2'd1) return {2{w[15:0]}};
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] s, input logic sx, input logic [11:0] a);
        int n = 1 << s;
        logic [31:0] v = 32'h0;
        logic [31:0] ones = 32'hFFFF_FFFF;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[int'(a) + k]) << (8 * k));
        if (sx && n < 4 && v[8*n-1]) v = v | (ones << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] s, input logic [11:0] a, input logic [31:0] w);
        int n = 1 << s;
        for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = w[8*k +: 8];
    endtask

    typedef struct {
        bit          timeout;
        int          gnt_lat;
        logic        other_gnt;
        logic        we, ld;
        logic [3:0]  sel;
        logic [9:0]  raddr;
        logic [31:0] din;
        logic        rvalid, other_rv, err;
        logic [31:0] rdata;
    } txn_t;

    // Drives one transaction on master m starting at a falling edge with the
    // DUT idle; samples everything on falling edges and returns one idle
    // cycle later.
    task automatic run_txn(input int m, input logic we, input logic [1:0] size, input logic sext,
                           input logic [11:0] addr, input logic [31:0] wdata, output txn_t r);
        bit got = 0;
        int lat = 0;
        if (m == 0) begin
            m0_we = we; m0_size = size; m0_sext = sext; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_size = size; m1_sext = sext; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            got = (m == 0) ? bit'(m0_gnt) : bit'(m1_gnt);
        end
        r.timeout   = !got;
        r.gnt_lat   = lat;
        r.other_gnt = (m == 0) ? m1_gnt : m0_gnt;
        r.we = ram_we; r.ld = ram_ld; r.sel = ram_sel; r.raddr = ram_addr; r.din = ram_din;
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        r.rvalid   = (m == 0) ? m0_rvalid : m1_rvalid;
        r.other_rv = (m == 0) ? m1_rvalid : m0_rvalid;
        r.rdata    = (m == 0) ? m0_rdata  : m1_rdata;
        r.err      = (m == 0) ? m0_err    : m1_err;
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        m0_req = 0; m0_we = 0; m0_size = 0; m0_sext = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_size = 0; m1_sext = 0; m1_addr = '0; m1_wdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({m0_gnt, m0_rvalid, m0_err, m0_rdata, m1_gnt, m1_rvalid, m1_err, m1_rdata,
             ram_we, ram_ld, ram_sel, ram_addr, ram_din} !== '0) begin
            n_err++; $display("FAIL reset_outputs: outputs not all zero (ram_sel=%b ram_din=%h)", ram_sel, ram_din);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        txn_t r;
        run_txn(0, 1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, r);
        ref_store(2'd2, 12'h010, 32'hDEADBEEF);
        n_cmp++; if (r.timeout || r.gnt_lat != 1) begin n_err++; $display("FAIL word_st_lat: got %0d want 1", r.gnt_lat); end
        n_cmp++; if ({r.we, r.ld} !== 2'b10) begin n_err++; $display("FAIL word_st_we_ld: got %b want 10", {r.we, r.ld}); end
        n_cmp++; if (r.sel !== 4'b1111) begin n_err++; $display("FAIL word_st_sel: got %b want 1111", r.sel); end
        n_cmp++; if (r.raddr !== 10'd4) begin n_err++; $display("FAIL word_st_addr: got %0d want 4", r.raddr); end
        n_cmp++; if (r.din !== 32'hDEADBEEF) begin n_err++; $display("FAIL word_st_din: got %h want deadbeef", r.din); end
        n_cmp++; if ({r.rvalid, r.err, r.other_rv, r.other_gnt} !== 4'b1000) begin n_err++; $display("FAIL word_st_resp: got %b want 1000", {r.rvalid, r.err, r.other_rv, r.other_gnt}); end
        n_cmp++; if (r.rdata !== 32'h0) begin n_err++; $display("FAIL word_st_rdata: got %h want 0", r.rdata); end
        run_txn(0, 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, r);
        n_cmp++; if (r.ld !== 1'b1 || r.we !== 1'b0) begin n_err++; $display("FAIL word_ld_ld: got ld=%b we=%b want 1 0", r.ld, r.we); end
        n_cmp++; if (r.rdata !== 32'hDEADBEEF || r.rvalid !== 1'b1) begin n_err++; $display("FAIL word_ld_rdata: got %h want deadbeef", r.rdata); end
    endtask

    task automatic test_byte();
        txn_t r;
        run_txn(0, 1'b1, 2'd0, 1'b0, 12'h013, 32'h00000080, r);
        ref_store(2'd0, 12'h013, 32'h80);
        n_cmp++; if (r.sel !== 4'b1000) begin n_err++; $display("FAIL byte_st_sel: got %b want 1000", r.sel); end
        n_cmp++; if (r.din !== 32'h80808080) begin n_err++; $display("FAIL byte_st_din: got %h want 80808080", r.din); end
        run_txn(0, 1'b0, 2'd0, 1'b1, 12'h013, 32'h0, r);
        n_cmp++; if (r.rdata !== 32'hFFFFFF80) begin n_err++; $display("FAIL byte_ld_sext: got %h want ffffff80", r.rdata); end
        n_cmp++; if (r.sel !== 4'b1000) begin n_err++; $display("FAIL byte_ld_sel: got %b want 1000", r.sel); end
        run_txn(0, 1'b0, 2'd0, 1'b0, 12'h013, 32'h0, r);
        n_cmp++; if (r.rdata !== 32'h00000080) begin n_err++; $display("FAIL byte_ld_zext: got %h want 00000080", r.rdata); end
    endtask

    task automatic test_half();
        txn_t r;
        run_txn(1, 1'b1, 2'd1, 1'b0, 12'h022, 32'h00001234, r);
        ref_store(2'd1, 12'h022, 32'h1234);
        n_cmp++; if (r.sel !== 4'b1100) begin n_err++; $display("FAIL half_st_sel: got %b want 1100", r.sel); end
        n_cmp++; if (r.din !== 32'h12341234) begin n_err++; $display("FAIL half_st_din: got %h want 12341234", r.din); end
        run_txn(1, 1'b0, 2'd1, 1'b1, 12'h022, 32'h0, r);
        n_cmp++; if (r.rdata !== 32'h00001234) begin n_err++; $display("FAIL half_ld: got %h want 00001234", r.rdata); end
        run_txn(1, 1'b0, 2'd2, 1'b0, 12'h020, 32'h0, r);
        n_cmp++; if (r.rdata !== 32'h12340000) begin n_err++; $display("FAIL half_word_view: got %h want 12340000", r.rdata); end
    endtask

    task automatic test_errors();
        txn_t r;
        logic [1:0]  sz [4] = '{2'd2, 2'd3, 2'd3, 2'd1};
        logic        we [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [11:0] ad [4] = '{12'h011, 12'h040, 12'h020, 12'h023};
        for (int i = 0; i < 4; i++) begin
            run_txn(i % 2, we[i], sz[i], 1'b1, ad[i], 32'hFFFF_FFFF, r);
            n_cmp++;
            if ({r.we, r.ld, r.rvalid, r.err} !== 4'b0011 || r.rdata !== 32'h0 || r.timeout) begin
                n_err++; $display("FAIL err_case%0d: got we=%b ld=%b rvalid=%b err=%b rdata=%h want 0 0 1 1 0",
                                  i, r.we, r.ld, r.rvalid, r.err, r.rdata);
            end
        end
        run_txn(0, 1'b0, 2'd2, 1'b0, 12'h020, 32'h0, r);
        n_cmp++; if (r.rdata !== 32'h12340000) begin n_err++; $display("FAIL err_ram_untouched: got %h want 12340000", r.rdata); end
    endtask

    task automatic test_alternate();
        logic [1:0] got, want;
        reset_pulse();
        m0_we = 0; m0_size = 2'd2; m0_sext = 0; m0_addr = 12'h010;
        m1_we = 0; m1_size = 2'd2; m1_sext = 0; m1_addr = 12'h020;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            got  = {m0_gnt, m1_gnt};
            want = (i % 3 == 1) ? (((i / 3) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
            n_cmp++;
            if (got !== want) begin n_err++; $display("FAIL alt_gnt cyc%0d: got %b want %b", i, got, want); end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tie();
        logic       exp_last = 1'b1;
        logic [1:0] pat, want;
        reset_pulse();
        for (int i = 0; i < 12; i++) begin
            pat = 2'($urandom_range(1, 3));
            m0_we = 0; m0_size = 2'd0; m0_addr = 12'($urandom_range(0, 255));
            m1_we = 0; m1_size = 2'd0; m1_addr = 12'($urandom_range(0, 255));
            m0_req = pat[1]; m1_req = pat[0];
            if (pat == 2'b11) want = exp_last ? 2'b10 : 2'b01;
            else              want = pat;
            exp_last = want[0];
            @(negedge clk);
            n_cmp++;
            if ({m0_gnt, m1_gnt} !== want) begin n_err++; $display("FAIL tie_gnt it%0d req=%b: got %b want %b", i, pat, {m0_gnt, m1_gnt}, want); end
            m0_req = 1'b0; m1_req = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        txn_t r;
        int   stray = 0;
        run_txn(1, 1'b1, 2'd2, 1'b0, 12'h100, 32'h11111111, r);
        ref_store(2'd2, 12'h100, 32'h11111111);
        m1_we = 1; m1_size = 2'd2; m1_addr = 12'h100; m1_wdata = 32'hCAFEF00D; m1_req = 1'b1;
        @(negedge clk);
        n_cmp++; if ({m1_gnt, ram_we} !== 2'b11) begin n_err++; $display("FAIL rstmid_access: got gnt,we=%b want 11", {m1_gnt, ram_we}); end
        rst = 1'b0;
        #1;
        n_cmp++; if ({ram_we, m1_gnt} !== 2'b00) begin n_err++; $display("FAIL rstmid_we_drop: got we,gnt=%b want 00", {ram_we, m1_gnt}); end
        m1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (m0_rvalid || m1_rvalid) stray++;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (m0_rvalid || m1_rvalid) stray++;
        end
        n_cmp++; if (stray != 0) begin n_err++; $display("FAIL rstmid_no_rvalid: got %0d strobes want 0", stray); end
        run_txn(0, 1'b0, 2'd2, 1'b0, 12'h100, 32'h0, r);
        n_cmp++; if (r.rdata !== 32'h11111111 || r.gnt_lat != 1) begin n_err++; $display("FAIL rstmid_word: got %h lat %0d want 11111111 lat 1", r.rdata, r.gnt_lat); end
    endtask

    task automatic test_random();
        txn_t        r;
        int          m;
        logic        we, sx, lg;
        logic [1:0]  sz;
        logic [11:0] a;
        logic [31:0] wd, exp_rd;
        for (int i = 0; i < 80; i++) begin
            m  = int'($urandom % 2);
            we = 1'($urandom % 2);
            sx = 1'($urandom % 2);
            sz = ($urandom % 10 == 0) ? 2'd3 : 2'($urandom % 3);
            a  = 12'($urandom_range(0, 255));
            if ($urandom % 4 != 0 && sz != 2'd3) a = a & ~12'((1 << sz) - 1);
            wd = $urandom;
            lg = ref_legal(sz, a);
            exp_rd = (lg && !we) ? ref_load(sz, sx, a) : 32'h0;
            run_txn(m, we, sz, sx, a, wd, r);
            n_cmp++;
            if (r.timeout || r.gnt_lat != 1 || r.other_gnt !== 1'b0 || r.rvalid !== 1'b1 || r.other_rv !== 1'b0) begin
                n_err++; $display("FAIL rnd_handshake it%0d: lat=%0d ogn=%b rv=%b orv=%b want 1 0 1 0", i, r.gnt_lat, r.other_gnt, r.rvalid, r.other_rv);
            end
            n_cmp++;
            if (r.err !== !lg || r.rdata !== exp_rd) begin
                n_err++; $display("FAIL rnd_resp it%0d sz=%0d a=%h: got err=%b rdata=%h want err=%b rdata=%h", i, sz, a, r.err, r.rdata, !lg, exp_rd);
            end
            n_cmp++;
            if ({r.we, r.ld} !== {lg && we, lg && !we}) begin
                n_err++; $display("FAIL rnd_strobe it%0d: got we,ld=%b want %b", i, {r.we, r.ld}, {lg && we, lg && !we});
            end
            if (lg) begin
                n_cmp++;
                if (r.sel !== ref_sel(sz, a) || r.raddr !== 10'(a >> 2)) begin
                    n_err++; $display("FAIL rnd_lane it%0d: got sel=%b addr=%0d want sel=%b addr=%0d", i, r.sel, r.raddr, ref_sel(sz, a), a >> 2);
                end
                if (we) begin
                    n_cmp++;
                    if (r.din !== ref_din(sz, wd)) begin n_err++; $display("FAIL rnd_din it%0d: got %h want %h", i, r.din, ref_din(sz, wd)); end
                    ref_store(sz, a, wd);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_alternate();
        test_tie();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
